// File: rtl/monitor_estados.sv
// Observes a 4-bit state stream, measures per-state dwell time and queues {state, dwell} records
// in a FWFT FIFO. Optional watchdog (stuck flag) enabled by defining MON_WATCHDOG_EN.
module monitor_estados #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned WD_MAX = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              state_in,
  input  logic                    clr_ovf,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [4+CNT_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic                    stuck
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned RecW = 4 + CNT_W;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (WD_MAX == 0)) begin : g_param_err
    $error("monitor_estados: DEPTH must be a power of two >= 2 and WD_MAX nonzero");
  end

  logic                 armed_q, armed_d;
  logic [3:0]           s_q, s_d;
  logic [CNT_W-1:0]     dwell_q, dwell_d;
  logic [RecW-1:0]      mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]      cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic push, pop, full, empty, wr_en, drop;

  always_comb begin
    push  = armed_q && (state_in != s_q);
    empty = (cnt_q == '0);
    full  = (cnt_q == LvlW'(DEPTH));
    pop   = !empty && rd_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
  end

  always_comb begin
    armed_d = armed_q;
    s_d     = s_q;
    dwell_d = dwell_q;
    if (!armed_q) begin
      armed_d = 1'b1;
      s_d     = state_in;
      dwell_d = CNT_W'(1);
    end else if (push) begin
      s_d     = state_in;
      dwell_d = CNT_W'(1);
    end else if (dwell_q != '1) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q  <= 1'b0;
      s_q      <= '0;
      dwell_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      armed_q <= armed_d;
      s_q     <= s_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage is cleared on reset so rd_data reads zero until the first record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {s_q, dwell_q};
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = mem_q[rd_ptr_q];
  assign level    = cnt_q;
  assign ovf      = ovf_q;

`ifdef MON_WATCHDOG_EN
  localparam logic [CNT_W:0] WdLimit = (CNT_W + 1)'(WD_MAX);

  logic             stuck_q, stuck_d;
  logic [CNT_W:0]   dwell_inc;

  always_comb begin
    dwell_inc = {1'b0, dwell_q} + 1'b1;
    stuck_d   = stuck_q;
    if (push) begin
      stuck_d = 1'b0;
    end else if (armed_q && (dwell_inc >= WdLimit)) begin
      stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

endmodule
